// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_pkg
//  Brief    : Shared constants, state encoding and helpers for the SCCB
//             (OV7670-style) register-port target.
//  Revision : 1.0 - initial release
// ============================================================================
package sccb_pkg;

  // Default 8-bit write ID of the OV7670 camera
  localparam logic [7:0] OV7670_ID   = 8'h42;
  // R/W flag position inside the ID byte; set means read
  localparam logic [7:0] SCCB_RD_BIT = 8'h01;

  // State encodings kept as plain constants so legacy code can share them
  localparam logic [3:0] C_ST_IDLE     = 4'd0;
  localparam logic [3:0] C_ST_DEV_ADDR = 4'd1;
  localparam logic [3:0] C_ST_DEV_ACK  = 4'd2;
  localparam logic [3:0] C_ST_REG_ADDR = 4'd3;
  localparam logic [3:0] C_ST_REG_ACK  = 4'd4;
  localparam logic [3:0] C_ST_WR_DATA  = 4'd5;
  localparam logic [3:0] C_ST_WR_ACK   = 4'd6;
  localparam logic [3:0] C_ST_RD_DATA  = 4'd7;
  localparam logic [3:0] C_ST_RD_NACK  = 4'd8;
  localparam logic [3:0] C_ST_IGNORE   = 4'd9;

  typedef enum logic [3:0] {
    ST_IDLE     = C_ST_IDLE,
    ST_DEV_ADDR = C_ST_DEV_ADDR,
    ST_DEV_ACK  = C_ST_DEV_ACK,
    ST_REG_ADDR = C_ST_REG_ADDR,
    ST_REG_ACK  = C_ST_REG_ACK,
    ST_WR_DATA  = C_ST_WR_DATA,
    ST_WR_ACK   = C_ST_WR_ACK,
    ST_RD_DATA  = C_ST_RD_DATA,
    ST_RD_NACK  = C_ST_RD_NACK,
    ST_IGNORE   = C_ST_IGNORE
  } sccb_state_t;

  // Read ID derived from a write ID
  function automatic logic [7:0] sccb_rd_id(input logic [7:0] wr_id);
    return wr_id | SCCB_RD_BIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_line_filter
//  Brief    : Two-flop synchronizer, consecutive-sample glitch filter and
//             edge detect for one open-drain bus line (idle level high).
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_rise;
  logic               r_fall;
  logic [c_cnt_w-1:0] r_cnt;

  // Bring the asynchronous line into the clk domain; reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/sccb_target.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_target
//  Brief    : SCCB/I2C register-port responder modelling the OV7670. Decodes
//             3-phase writes and 2-phase write + 2-phase read transactions,
//             ACKs by pulling SDA low and keeps a 256x8 register file.
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID     = OV7670_ID,
  parameter int         FILTER_LEN = 3,
  parameter int         HOLD_CYC   = 4,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCL,
  inout  wire              SDA,
  output logic             wr_valid,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  input  logic [7:0]       dbg_addr,
  output logic [7:0]       dbg_data,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int c_hold_w = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'((HOLD_CYC > 1) ? HOLD_CYC - 1 : 0);
  localparam logic [7:0] c_rd_id = sccb_rd_id(DEV_ID);

  // Conditioned line events
  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic w_last_bit;
  logic w_commit;
  logic w_fall_low;
  logic [7:0] w_byte;

  // Protocol state
  sccb_state_t         r_state;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_ptr;
  logic                r_rd_flag;
  logic [7:0]          r_rd_byte;
  logic                r_sda_low;
  logic                r_pend_low;
  logic [c_hold_w-1:0] r_hold_cnt;

  // Storage and write-report outputs
  logic [7:0]          r_regfile [256];
  logic                r_wr_valid;
  logic [7:0]          r_wr_addr;
  logic [7:0]          r_wr_data;
  logic [CNT_W-1:0]    r_txn_count;

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .rst_n   (reset),
    .i_line  (SCL),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .rst_n   (reset),
    .i_line  (SDA),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high
  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift[6:0], w_sda_lvl};
  // Data byte completes on its 8th rise with no START/STOP competing
  assign w_commit   = w_scl_rise & ~w_start & ~w_stop & w_last_bit &
                      (r_state == ST_WR_DATA);

  // SDA level to present in the low phase that follows an SCL fall
  always_comb begin
    w_fall_low = 1'b0;
    case (r_state)
      ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: w_fall_low = 1'b1;
      ST_RD_DATA:                        w_fall_low = ~r_rd_byte[~r_bit_cnt];
      default:                           w_fall_low = 1'b0;
    endcase
  end

  // Protocol sequencer: START/STOP first, then delayed SDA drive and bit handling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_rd_flag  <= 1'b0;
      r_rd_byte  <= 8'h00;
      r_sda_low  <= 1'b0;
      r_pend_low <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_start) begin
      r_state    <= ST_DEV_ADDR;
      r_bit_cnt  <= 3'd0;
      r_sda_low  <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_stop) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_sda_low  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      // SDA only changes HOLD_CYC clk after an accepted SCL fall
      if (w_scl_fall && (r_state != ST_IDLE)) begin
        if (HOLD_CYC <= 1) begin
          r_sda_low <= w_fall_low;
        end else begin
          r_pend_low <= w_fall_low;
          r_hold_cnt <= c_hold_load;
        end
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
        if (r_hold_cnt == c_hold_w'(1)) begin
          r_sda_low <= r_pend_low;
        end
      end

      if (w_scl_rise) begin
        case (r_state)
          ST_DEV_ADDR: begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              if (w_byte == DEV_ID) begin
                r_state   <= ST_DEV_ACK;
                r_rd_flag <= 1'b0;
              end else if (w_byte == c_rd_id) begin
                r_state   <= ST_DEV_ACK;
                r_rd_flag <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_REG_ADDR: begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_ptr   <= w_byte;
              r_state <= ST_REG_ACK;
            end
          end
          ST_WR_DATA: begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_state <= ST_WR_ACK;
            end
          end
          ST_DEV_ACK: begin
            r_bit_cnt <= 3'd0;
            if (r_rd_flag) begin
              r_state   <= ST_RD_DATA;
              r_rd_byte <= r_regfile[r_ptr];
            end else begin
              r_state <= ST_REG_ADDR;
            end
          end
          ST_REG_ACK: begin
            r_bit_cnt <= 3'd0;
            r_state   <= ST_WR_DATA;
          end
          ST_RD_DATA: begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              r_state <= ST_RD_NACK;
            end
          end
          // One byte per write transaction; anything after the ACK slot is NACKed
          ST_WR_ACK, ST_RD_NACK: begin
            r_bit_cnt <= 3'd0;
            r_state   <= ST_IGNORE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Register file, committed-write report and saturating commit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        r_regfile[i] <= 8'h00;
      end
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_txn_count <= '0;
    end else begin
      r_wr_valid <= w_commit;
      if (w_commit) begin
        r_regfile[r_ptr] <= w_byte;
        r_wr_addr        <= r_ptr;
        r_wr_data        <= w_byte;
        if (r_txn_count != {CNT_W{1'b1}}) begin
          r_txn_count <= r_txn_count + 1'b1;
        end
      end
    end
  end

  // Open drain: only ever pull low, and let go the instant reset asserts
  assign SDA       = (r_sda_low & reset) ? 1'b0 : 1'bz;

  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign dbg_data  = r_regfile[dbg_addr];
  assign busy      = (r_state != ST_IDLE);
  assign txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sccb_target
//  Brief    : Bit-banged SCCB master driving sccb_target, with a transaction
//             level reference model of the register port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_target;

  localparam int Q = 16;  // quarter SCL period in clk cycles

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       scl       = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] dbg_addr  = 8'h00;
  wire        sda_bus;

  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dbg_data;
  logic       busy;
  logic [7:0] txn_count;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  sccb_target #(
    .DEV_ID     (8'h42),
    .FILTER_LEN (3),
    .HOLD_CYC   (4),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (sda_bus),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  // Observers of DUT activity
  int         wv_count    = 0;
  int         dut_low_cnt = 0;
  logic [7:0] last_wa     = 8'h00;
  logic [7:0] last_wd     = 8'h00;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_count++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt++;
  end

  // Reference model: register contents, pointer, commit count
  logic [7:0] m_regs [256];
  logic [7:0] m_ptr;
  int         m_count;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_ptr   = 8'h00;
    m_count = 0;
  endtask

  // Write-style transaction rules: only the write ID is answered, the
  // sub-address sets the pointer, and only the first data byte lands.
  task automatic model_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] d0,
                             input int ndata, output logic [3:0] acks, output int commits);
    acks    = 4'b0000;
    commits = 0;
    if (id == 8'h42) begin
      acks[0] = 1'b1;
      acks[1] = 1'b1;
      m_ptr   = sub;
      if (ndata > 0) begin
        acks[2]     = 1'b1;
        m_regs[sub] = d0;
        m_count     = (m_count == 255) ? 255 : m_count + 1;
        commits     = 1;
      end
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; scl = 1'b1; wait_q(1);
    m_sda_low = 1'b1; wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q(1);
    scl = 1'b1; wait_q(1);
    m_sda_low = 1'b0; wait_q(2);
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; wait_q(1);
    scl = 1'b1; wait_q(2);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; wait_q(1);
    scl = 1'b1; wait_q(1);
    b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    wait_q(1);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(1'b1);  // master NACK
  endtask

  task automatic txn_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] d0,
                           input logic [7:0] d1, input int ndata, output logic [3:0] acks);
    acks = 4'b0000;
    bus_start();
    put_byte(id, acks[0]);
    put_byte(sub, acks[1]);
    if (ndata > 0) put_byte(d0, acks[2]);
    if (ndata > 1) put_byte(d1, acks[3]);
    bus_stop();
  endtask

  task automatic txn_read(output logic ack, output logic [7:0] v);
    bus_start();
    put_byte(8'h43, ack);
    get_byte(v);
    bus_stop();
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(name, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  typedef struct {
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] d0;
    logic [7:0] d1;
    int         ndata;
    logic [3:0] exp_acks;
    int         exp_commits;
    logic [7:0] exp_wa;
    logic [7:0] exp_wd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] acks;
    logic [3:0] m_acks;
    int         commits;
    int         wv0;
    int         low0;
    logic       ack;
    logic [7:0] rv;
    logic       b;

    vecs[0] = '{8'h42, 8'h12, 8'h80, 8'h00, 1, 4'b0111, 1, 8'h12, 8'h80};
    vecs[1] = '{8'h42, 8'h3A, 8'h04, 8'h00, 1, 4'b0111, 1, 8'h3A, 8'h04};
    vecs[2] = '{8'h60, 8'h12, 8'h55, 8'h00, 1, 4'b0000, 0, 8'h00, 8'h00};
    vecs[3] = '{8'h42, 8'h3A, 8'h00, 8'h00, 0, 4'b0011, 0, 8'h00, 8'h00};
    vecs[4] = '{8'h42, 8'h50, 8'hA5, 8'h5A, 2, 4'b0111, 1, 8'h50, 8'hA5};
    vecs[5] = '{8'h44, 8'h10, 8'h11, 8'h00, 1, 4'b0000, 0, 8'h00, 8'h00};

    model_reset();

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sda", {31'h0, sda_bus}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {24'h0, wr_data}, 32'h0);
    check("rst_txn_count", {24'h0, txn_count}, 32'h0);
    check_reg("rst_reg00", 8'h00, 8'h00);
    check_reg("rst_regff", 8'hFF, 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      wv0  = wv_count;
      low0 = dut_low_cnt;
      txn_write(vecs[v].id, vecs[v].sub, vecs[v].d0, vecs[v].d1, vecs[v].ndata, acks);
      model_write(vecs[v].id, vecs[v].sub, vecs[v].d0, vecs[v].ndata, m_acks, commits);
      check($sformatf("tbl%0d_acks", v), {28'h0, acks}, {28'h0, vecs[v].exp_acks});
      check($sformatf("tbl%0d_commits", v), wv_count - wv0, vecs[v].exp_commits);
      check($sformatf("tbl%0d_sda_driven", v), {31'h0, (dut_low_cnt != low0)}, {31'h0, vecs[v].exp_acks[0]});
      if (vecs[v].exp_commits != 0) begin
        check($sformatf("tbl%0d_wr_addr", v), {24'h0, last_wa}, {24'h0, vecs[v].exp_wa});
        check($sformatf("tbl%0d_wr_data", v), {24'h0, last_wd}, {24'h0, vecs[v].exp_wd});
      end
      check($sformatf("tbl%0d_busy", v), {31'h0, busy}, 32'h0);
      check($sformatf("tbl%0d_txn_count", v), {24'h0, txn_count}, m_count);
      check_reg($sformatf("tbl%0d_reg", v), vecs[v].sub, m_regs[vecs[v].sub]);
    end
    check_reg("foreign_keeps_reg12", 8'h12, 8'h80);

    // Read back: pointer set by a 2-phase write, then a read
    txn_write(8'h42, 8'h3A, 8'h00, 8'h00, 0, acks);
    model_write(8'h42, 8'h3A, 8'h00, 0, m_acks, commits);
    wv0 = wv_count;
    txn_read(ack, rv);
    check("read_id_ack", {31'h0, ack}, 32'h1);
    check("read_data", {24'h0, rv}, 32'h04);
    check("read_no_commit", wv_count - wv0, 0);
    check("read_txn_count", {24'h0, txn_count}, m_count);

    // Abort a data byte after 5 bits
    wv0 = wv_count;
    bus_start();
    put_byte(8'h42, ack);
    put_byte(8'h20, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    bus_stop();
    m_ptr = 8'h20;
    check("abort_no_commit", wv_count - wv0, 0);
    check_reg("abort_reg20", 8'h20, 8'h00);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_txn_count", {24'h0, txn_count}, m_count);
    txn_read(ack, rv);
    check("abort_ptr_kept", {24'h0, rv}, {24'h0, m_regs[8'h20]});

    // Asynchronous reset while the target is ACKing the sub-address
    bus_start();
    put_byte(8'h42, ack);
    for (int i = 7; i >= 0; i--) begin
      b = 1'(8'h11 >> i);
      put_bit(b);
    end
    m_sda_low = 1'b0;
    #1;
    check("regack_sda_low", {31'h0, sda_bus}, 32'h0);
    check("regack_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("reset_sda_released", {31'h0, sda_bus}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    scl = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check("postrst_txn_count", {24'h0, txn_count}, 32'h0);
    check_reg("postrst_reg12", 8'h12, 8'h00);
    wv0 = wv_count;
    txn_write(8'h42, 8'h11, 8'hC3, 8'h00, 1, acks);
    model_write(8'h42, 8'h11, 8'hC3, 1, m_acks, commits);
    check("postrst_acks", {28'h0, acks}, {28'h0, m_acks});
    check("postrst_commit", wv_count - wv0, 1);
    check_reg("postrst_reg11", 8'h11, 8'hC3);
    check("postrst_txn", {24'h0, txn_count}, 32'h1);

    // Randomized transactions against the model
    for (int n = 0; n < 12; n++) begin
      int         kind;
      logic [7:0] id, sub, d0, d1;
      int         nd;
      kind = $urandom_range(0, 3);
      sub  = 8'($urandom);
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      wv0  = wv_count;
      if (kind == 2) begin
        txn_read(ack, rv);
        check($sformatf("rnd%0d_rd_ack", n), {31'h0, ack}, 32'h1);
        check($sformatf("rnd%0d_rd_data", n), {24'h0, rv}, {24'h0, m_regs[m_ptr]});
        check($sformatf("rnd%0d_rd_commits", n), wv_count - wv0, 0);
      end else begin
        if (kind == 3) begin
          id = 8'($urandom);
          if (id[7:1] == 7'h21) id = id ^ 8'h80;
        end else begin
          id = 8'h42;
        end
        nd = (kind == 1) ? 0 : $urandom_range(1, 2);
        txn_write(id, sub, d0, d1, nd, acks);
        model_write(id, sub, d0, nd, m_acks, commits);
        check($sformatf("rnd%0d_acks", n), {28'h0, acks}, {28'h0, m_acks});
        check($sformatf("rnd%0d_commits", n), wv_count - wv0, commits);
        check_reg($sformatf("rnd%0d_reg", n), sub, m_regs[sub]);
      end
      check($sformatf("rnd%0d_txn_count", n), {24'h0, txn_count}, m_count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
